sigmoid_backprop: RTL and testbench

SIGMOID_BACKPROP -- requirements
Module: sigmoid_backprop

---
 rtl/sigmoid_backprop_pkg.sv | 38 +++
 rtl/sigmoid_backprop_if.sv | 36 +++
 rtl/sigmoid_backprop_qmul.sv | 19 +
 rtl/sigmoid_backprop.sv | 141 ++++++++++++++
 tb/tb_sigmoid_backprop.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/sigmoid_backprop_pkg.sv
// Shared fixed-point definitions for the sigmoid backprop block: defaults, FSM states, reduce-to-width.
// SIGMOID_BACKPROP_SAT_EN selects clamping reductions; otherwise reductions wrap.
package nn_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int FRAC_DEF  = 8;
  localparam int ONE       = 1 << FRAC_DEF;
  localparam int MAXW      = 64;

  typedef enum logic [3:0] {
    IDLE,
    ERR,
    DERIV,
    DELTA,
    SCALE,
    UPD1,
    UPD2,
    UPDB,
    DONE
  } state_e;

  // Reduce a sign-extended value to w bits; result stays sign-extended to MAXW.
  function automatic logic signed [MAXW-1:0] reduce_w(input logic signed [MAXW-1:0] v,
                                                      input int w);
`ifdef SIGMOID_BACKPROP_SAT_EN
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    hi = (MAXW'(1) <<< (w - 1)) - MAXW'(1);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    return (v <<< (MAXW - w)) >>> (MAXW - w);
`endif
  endfunction

endpackage

// File: rtl/sigmoid_backprop_if.sv
// Operand/result bundle for sigmoid_backprop: valid/ready on both sides.
// master = upstream/downstream environment, slave = the backprop block.
interface sigmoid_backprop_if
  import nn_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] input1;
  logic signed [WIDTH-1:0] input2;
  logic signed [WIDTH-1:0] weight1;
  logic signed [WIDTH-1:0] weight2;
  logic signed [WIDTH-1:0] bias;
  logic signed [WIDTH-1:0] y;
  logic signed [WIDTH-1:0] target;
  logic signed [WIDTH-1:0] lr;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] weight1_new;
  logic signed [WIDTH-1:0] weight2_new;
  logic signed [WIDTH-1:0] bias_new;
  logic signed [WIDTH-1:0] delta;

  modport master (
    output in_valid, input1, input2, weight1, weight2, bias, y, target, lr, out_ready,
    input  in_ready, out_valid, weight1_new, weight2_new, bias_new, delta
  );

  modport slave (
    input  in_valid, input1, input2, weight1, weight2, bias, y, target, lr, out_ready,
    output in_ready, out_valid, weight1_new, weight2_new, bias_new, delta
  );

endinterface

// File: rtl/sigmoid_backprop_qmul.sv
// Signed fixed-point multiply: full 2*WIDTH product, floor shift by FRAC, reduce to WIDTH.
// Purely combinational; reduction mode follows SIGMOID_BACKPROP_SAT_EN.
module qmul
  import nn_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH-1:0] p_o
);

  logic signed [2*WIDTH-1:0] prod;

  assign prod = a_i * b_i;
  assign p_o  = WIDTH'(reduce_w(MAXW'(prod >>> FRAC), WIDTH));

endmodule

// File: rtl/sigmoid_backprop.sv
// Output-node backprop step for a 2-input sigmoid neuron (SIGMOID_BACKPROP_SAT_EN: clamp, else wrap).
// 7 edges accept-to-out_valid, 9-cycle issue interval; holds DONE until out_ready, in_ready only in IDLE.
module sigmoid_backprop
  import nn_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  sigmoid_backprop_if.slave bp
);

  typedef logic signed [WIDTH-1:0] word_t;

  localparam word_t ONE_W = word_t'(1 << FRAC);

  state_e state_q;
  word_t  x1_q, x2_q, w1_q, w2_q, b_q, y_q, t_q, lr_q;
  word_t  e_q, d_q, delta_q, g_q;
  word_t  w1n_q, w2n_q, bn_q;
  logic   out_valid_q;

  word_t  mul_a, mul_b, mul_p, one_minus_y;

  function automatic word_t sub_red(input word_t a, input word_t b);
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    return word_t'(reduce_w(MAXW'(s), WIDTH));
  endfunction

  assign one_minus_y = sub_red(ONE_W, y_q);

  // One multiplier serves every product; the state picks its operands.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      DERIV:   begin mul_a = y_q;  mul_b = one_minus_y; end
      DELTA:   begin mul_a = e_q;  mul_b = d_q;         end
      SCALE:   begin mul_a = lr_q; mul_b = delta_q;     end
      UPD1:    begin mul_a = g_q;  mul_b = x1_q;        end
      UPD2:    begin mul_a = g_q;  mul_b = x2_q;        end
      default: begin mul_a = '0;   mul_b = '0;          end
    endcase
  end

  qmul #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_qmul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      x1_q        <= '0;
      x2_q        <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      b_q         <= '0;
      y_q         <= '0;
      t_q         <= '0;
      lr_q        <= '0;
      e_q         <= '0;
      d_q         <= '0;
      delta_q     <= '0;
      g_q         <= '0;
      w1n_q       <= '0;
      w2n_q       <= '0;
      bn_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bp.in_valid) begin
            x1_q    <= bp.input1;
            x2_q    <= bp.input2;
            w1_q    <= bp.weight1;
            w2_q    <= bp.weight2;
            b_q     <= bp.bias;
            y_q     <= bp.y;
            t_q     <= bp.target;
            lr_q    <= bp.lr;
            state_q <= ERR;
          end
        end
        ERR: begin
          e_q     <= sub_red(y_q, t_q);
          state_q <= DERIV;
        end
        DERIV: begin
          d_q     <= mul_p;
          state_q <= DELTA;
        end
        DELTA: begin
          delta_q <= mul_p;
          state_q <= SCALE;
        end
        SCALE: begin
          g_q     <= mul_p;
          state_q <= UPD1;
        end
        UPD1: begin
          w1n_q   <= sub_red(w1_q, mul_p);
          state_q <= UPD2;
        end
        UPD2: begin
          w2n_q   <= sub_red(w2_q, mul_p);
          state_q <= UPDB;
        end
        UPDB: begin
          bn_q        <= sub_red(b_q, g_q);
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bp.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bp.in_ready    = (state_q == IDLE);
  assign bp.out_valid   = out_valid_q;
  assign bp.delta       = delta_q;
  assign bp.weight1_new = w1n_q;
  assign bp.weight2_new = w2n_q;
  assign bp.bias_new    = bn_q;

endmodule

// File: tb/tb_sigmoid_backprop.sv
// Scoreboard bench for sigmoid_backprop: directed vectors with hand-computed results.
// Expected saturation result follows SIGMOID_BACKPROP_SAT_EN.
module tb_sigmoid_backprop;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sigmoid_backprop_if #(.WIDTH(16)) bif ();

  sigmoid_backprop #(
    .WIDTH (16),
    .FRAC  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bif)
  );

  typedef struct {
    logic [15:0] y, t, lr, x1, x2, w1, w2, b;
    logic [15:0] d, w1n, w2n, bn;
  } vec_t;

`ifdef SIGMOID_BACKPROP_SAT_EN
  localparam logic [15:0] SAT_W1 = 16'h7FFF;
`else
  localparam logic [15:0] SAT_W1 = 16'hEFFF;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  vec_t sb_q[$];
  vec_t exp_v;
  vec_t v_nom, v_mix, v_zero, v_sat;
  vec_t bb[3];
  int   acc[3];
  int   n;
  bit   quiet;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic [15:0] y, t, lr, x1, x2, w1, w2, b,
                              input logic [15:0] d, w1n, w2n, bn);
    vec_t v;
    v.y = y; v.t = t; v.lr = lr; v.x1 = x1; v.x2 = x2;
    v.w1 = w1; v.w2 = w2; v.b = b;
    v.d = d; v.w1n = w1n; v.w2n = w2n; v.bn = bn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && bif.out_valid === 1'b1 && bif.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 16'd1, 16'd0);
      end else begin
        exp_v = sb_q.pop_front();
        chk("delta",       bif.delta,       exp_v.d);
        chk("weight1_new", bif.weight1_new, exp_v.w1n);
        chk("weight2_new", bif.weight2_new, exp_v.w2n);
        chk("bias_new",    bif.bias_new,    exp_v.bn);
      end
    end
  end

  task automatic drive(input vec_t v);
    bif.y = v.y; bif.target = v.t; bif.lr = v.lr;
    bif.input1 = v.x1; bif.input2 = v.x2;
    bif.weight1 = v.w1; bif.weight2 = v.w2; bif.bias = v.b;
  endtask

  // Called #1 after an edge; waits for in_ready with a bound.
  task automatic wait_rdy();
    int k = 0;
    while (bif.in_ready !== 1'b1 && k < 40) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 40) chk("in_ready_timeout", 16'd0, 16'd1);
  endtask

  task automatic send(input vec_t v, input bit push);
    wait_rdy();
    drive(v);
    bif.in_valid = 1'b1;
    if (push) sb_q.push_back(v);
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
  endtask

  task automatic wait_ov(output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1; edges++;
    end while (bif.out_valid !== 1'b1 && edges < 20);
  endtask

  task automatic run_one(input vec_t v, input string name);
    int e;
    send(v, 1'b1);
    wait_ov(e);
    chk(name, 16'(e), 16'd7);
    @(posedge clk); #1;
  endtask

  initial begin
    v_nom  = mk(16'h00B7, 16'h0100, 16'h0080, 16'h0100, 16'h0000, 16'h0200, 16'h0300, 16'h0000,
                16'hFFF1, 16'h0208, 16'h0300, 16'h0008);
    v_mix  = mk(16'h00C0, 16'h0040, 16'h0100, 16'h0080, 16'hFF00, 16'h0100, 16'h0000, 16'h0010,
                16'h0018, 16'h00F4, 16'h0018, 16'hFFF8);
    v_zero = mk(16'h0080, 16'h0080, 16'h0100, 16'h1234, 16'hFF00, 16'h0ABC, 16'hF123, 16'h0042,
                16'h0000, 16'h0ABC, 16'hF123, 16'h0042);
    v_sat  = mk(16'h0080, 16'h0100, 16'h0800, 16'h7FFF, 16'h0000, 16'h7000, 16'h0000, 16'h0000,
                16'hFFE0, SAT_W1, 16'h0000, 16'h0100);

    rst = 1'b0;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    drive(v_zero);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready",  16'(bif.in_ready),  16'd1);
    chk("rst_out_valid", 16'(bif.out_valid), 16'd0);
    chk("rst_delta",     bif.delta,          16'h0000);
    chk("rst_w1n",       bif.weight1_new,    16'h0000);
    chk("rst_w2n",       bif.weight2_new,    16'h0000);
    chk("rst_bn",        bif.bias_new,       16'h0000);

    run_one(v_nom,  "latency_nom");
    run_one(v_mix,  "latency_mix");
    run_one(v_zero, "latency_zero");
    run_one(v_sat,  "latency_sat");

    // Backpressure: hold DONE for 5 cycles while poking in_valid.
    bif.out_ready = 1'b0;
    send(v_nom, 1'b1);
    wait_ov(n);
    chk("latency_bp", 16'(n), 16'd7);
    bif.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 16'(bif.out_valid), 16'd1);
      chk("bp_in_ready",  16'(bif.in_ready),  16'd0);
      chk("bp_delta",     bif.delta,          v_nom.d);
      chk("bp_w1n",       bif.weight1_new,    v_nom.w1n);
      @(posedge clk); #1;
      bif.in_valid = ~bif.in_valid;
    end
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 16'(bif.out_valid), 16'd0);
    chk("bp_release_in_ready",  16'(bif.in_ready),  16'd1);
    quiet = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (bif.out_valid !== 1'b0) quiet = 1'b0;
    end
    chk("bp_no_spurious", 16'(quiet), 16'd1);

    // Reset while the block is in SCALE; this transaction is abandoned.
    send(v_mix, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 16'(bif.out_valid), 16'd0);
    chk("mid_rst_delta",     bif.delta,          16'h0000);
    chk("mid_rst_w1n",       bif.weight1_new,    16'h0000);
    chk("mid_rst_w2n",       bif.weight2_new,    16'h0000);
    chk("mid_rst_bn",        bif.bias_new,       16'h0000);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", 16'(bif.in_ready), 16'd1);
    run_one(v_nom, "latency_after_rst");

    // Back-to-back with in_valid held high.
    bb[0] = v_nom; bb[1] = v_mix; bb[2] = v_sat;
    bif.out_ready = 1'b1;
    bif.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_rdy();
      drive(bb[k]);
      sb_q.push_back(bb[k]);
      @(posedge clk); #1;
      acc[k] = cyc;
    end
    bif.in_valid = 1'b0;
    chk("b2b_interval_0", 16'(acc[1] - acc[0]), 16'd9);
    chk("b2b_interval_1", 16'(acc[2] - acc[1]), 16'd9);

    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("scoreboard_drained", 16'(sb_q.size()), 16'd0);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
